// File: rtl/key_conditioner.sv
// Purpose: synchronise, debounce and edge-detect raw push-button pins into clean pressed levels and pulses.
// Latency: a steady raw change shows on keys_o 2 + DEB_CYCLES clock edges after the edge that first samples it.
// Backpressure: none; outputs are free-running levels and single-cycle pulses with no flow control.

package board_pkg;
  localparam int KEYS_W        = 4;
  localparam int BOARD_CLK_MHZ = 50;
endpackage

module key_conditioner #(
  parameter int KEYS_W        = board_pkg::KEYS_W,
  parameter int BOARD_CLK_MHZ = board_pkg::BOARD_CLK_MHZ,
  parameter int DEBOUNCE_US   = 10000,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [KEYS_W-1:0] keys_raw_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] keys_press_o,
  output logic [KEYS_W-1:0] keys_release_o
);

  localparam int DEB_CYCLES = BOARD_CLK_MHZ * DEBOUNCE_US;
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  // A zero-length debounce window has no meaningful counter; refuse to build.
  if (DEB_CYCLES < 1) begin : g_bad_window
    $error("key_conditioner: BOARD_CLK_MHZ * DEBOUNCE_US must be at least 1");
  end

  logic [KEYS_W-1:0]            sync1_q,   sync1_d;
  logic [KEYS_W-1:0]            sync2_q,   sync2_d;
  logic [KEYS_W-1:0]            stable_q,  stable_d;
  logic [KEYS_W-1:0][CNT_W-1:0] cnt_q,     cnt_d;
  logic [KEYS_W-1:0]            keys_q,    keys_d;
  logic [KEYS_W-1:0]            press_q,   press_d;
  logic [KEYS_W-1:0]            release_q, release_d;

  // Next-state: polarity fix before sync1, per-key mismatch counting, and edge pulses off the stable level.
  always_comb begin
    // Inverting ahead of the synchroniser means a 1 anywhere past sync1 always means pressed.
    sync1_d = (ACTIVE_LOW != 0) ? ~keys_raw_i : keys_raw_i;
    sync2_d = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int k = 0; k < KEYS_W; k++) begin
      if (sync2_q[k] == stable_q[k]) begin
        // Any agreement, even for one cycle, restarts the window so bounce never accumulates.
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        stable_d[k] = ~stable_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
    // keys_o trails stable by one register so the level and its pulse appear on the same edge.
    keys_d    = stable_q;
    press_d   = stable_q & ~keys_q;
    release_d = ~stable_q & keys_q;
  end

  // State registers with synchronous reset; reset clears the synchroniser so a held key is re-reported.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      keys_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      keys_q    <= keys_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign keys_o         = keys_q;
  assign keys_press_o   = press_q;
  assign keys_release_o = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Purpose: directed check of key_conditioner debouncing with a four-cycle window on three active-low keys.
// Latency: outputs are expected to change at the seventh falling edge after the raw change is driven.
// Backpressure: none; stimulus is a fixed-length directed sequence.

module tb_key_conditioner;

  localparam int CHG = 7;

  logic       clk;
  logic       rst;
  logic [2:0] raw;
  logic [2:0] keys;
  logic [2:0] press;
  logic [2:0] rel;

  int n_checks = 0;
  int n_pass   = 0;

  key_conditioner #(
    .KEYS_W       (3),
    .BOARD_CLK_MHZ(1),
    .DEBOUNCE_US  (4),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .keys_raw_i    (raw),
    .keys_o        (keys),
    .keys_press_o  (press),
    .keys_release_o(rel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  // Watch n falling edges after a raw change driven at a falling edge; the change lands at edge CHG.
  task automatic watch(input string tag, input int n, input logic [2:0] k_before,
                       input logic [2:0] k_after, input logic [2:0] press_v, input logic [2:0] rel_v);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk($sformatf("%s keys c%0d", tag, i), keys, (i >= CHG) ? k_after : k_before);
      chk($sformatf("%s press c%0d", tag, i), press, (i == CHG) ? press_v : 3'b000);
      chk($sformatf("%s release c%0d", tag, i), rel, (i == CHG) ? rel_v : 3'b000);
    end
  endtask

  initial begin
    rst = 1'b1;
    raw = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset keys", keys, 3'b000);
    chk("reset press", press, 3'b000);
    chk("reset release", rel, 3'b000);
    rst = 1'b0;
    watch("idle", 8, 3'b000, 3'b000, 3'b000, 3'b000);

    // Clean press of key 0, then its release.
    raw = 3'b110;
    watch("press0", 10, 3'b000, 3'b001, 3'b001, 3'b000);
    raw = 3'b111;
    watch("release0", 10, 3'b001, 3'b000, 3'b000, 3'b001);

    // Three-cycle glitch on key 1 never reaches the four-cycle window.
    raw = 3'b101;
    watch("glitch_low", 3, 3'b000, 3'b000, 3'b000, 3'b000);
    raw = 3'b111;
    watch("glitch_high", 10, 3'b000, 3'b000, 3'b000, 3'b000);

    // Bounce on key 0: 1,0,1,0 then held at 0.
    raw = 3'b111; watch("bounce_a", 1, 3'b000, 3'b000, 3'b000, 3'b000);
    raw = 3'b110; watch("bounce_b", 1, 3'b000, 3'b000, 3'b000, 3'b000);
    raw = 3'b111; watch("bounce_c", 1, 3'b000, 3'b000, 3'b000, 3'b000);
    raw = 3'b110;
    watch("bounce_hold", 10, 3'b000, 3'b001, 3'b001, 3'b000);
    raw = 3'b111;
    watch("bounce_rel", 10, 3'b001, 3'b000, 3'b000, 3'b001);

    // Keys 0 and 2 together, held then released together.
    raw = 3'b010;
    watch("simul_press", 10, 3'b000, 3'b101, 3'b101, 3'b000);
    raw = 3'b111;
    watch("simul_rel", 10, 3'b101, 3'b000, 3'b000, 3'b101);

    // Reset lands after two count cycles on key 2; the held key is re-reported after reset.
    raw = 3'b011;
    watch("mid_count", 4, 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b1;
    watch("in_reset", 2, 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    watch("post_reset", 10, 3'b000, 3'b100, 3'b100, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
